// File: rtl/ps2_keyboard_rx.sv
// Receive-only PS/2 keyboard front end: synchronises and de-glitches the pins,
// deserialises 11-bit odd-parity frames and holds the scan code under ready/rdn.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 2500
) (
    input  logic       ps2i_clk,
    input  logic       ps2i_rst,
    input  logic       ps2i_kbd_clk,
    input  logic       ps2i_kbd_data,
    input  logic       ps2i_rdn,
    output logic       ps2o_data_ready,
    output logic [7:0] ps2o_scan_code,
    output logic       ps2o_frame_err,
    output logic       ps2o_overrun,
    output logic       ps2o_busy
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Pin index 0 is the PS/2 clock, index 1 the PS/2 data.
    logic [1:0]     sync1_q, sync2_q, filt_q;
    logic [FCW-1:0] fcnt_q [2];
    logic           clk_prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge ps2i_clk or negedge ps2i_rst) begin
        if (!ps2i_rst) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            filt_q     <= 2'b11;
            fcnt_q[0]  <= '0;
            fcnt_q[1]  <= '0;
            clk_prev_q <= 1'b1;
        end else begin
            sync1_q    <= {ps2i_kbd_data, ps2i_kbd_clk};
            sync2_q    <= sync1_q;
            clk_prev_q <= filt_q[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FCW'(FILTER_LEN - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic kbd_fall;
    logic kbd_data;
    assign kbd_fall = clk_prev_q & ~filt_q[0];
    assign kbd_data = filt_q[1];

    state_t      state_q, state_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        parity_ok_q, parity_ok_d;
    logic [15:0] timeout_q, timeout_d;
    logic        frame_err_q, frame_err_d;
    logic        data_ready_q, data_ready_d;
    logic [7:0]  scan_code_q, scan_code_d;
    logic        overrun_q, overrun_d;
    logic        good_frame;
    logic        rd_hit;

    always_ff @(posedge ps2i_clk or negedge ps2i_rst) begin
        if (!ps2i_rst) begin
            state_q      <= S_IDLE;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            parity_ok_q  <= 1'b0;
            timeout_q    <= '0;
            frame_err_q  <= 1'b0;
            data_ready_q <= 1'b0;
            scan_code_q  <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            parity_ok_q  <= parity_ok_d;
            timeout_q    <= timeout_d;
            frame_err_q  <= frame_err_d;
            data_ready_q <= data_ready_d;
            scan_code_q  <= scan_code_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rd_hit = data_ready_q & ~ps2i_rdn;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        parity_ok_d  = parity_ok_q;
        timeout_d    = timeout_q;
        frame_err_d  = 1'b0;
        good_frame   = 1'b0;
        data_ready_d = data_ready_q;
        scan_code_d  = scan_code_q;
        overrun_d    = overrun_q;

        if (state_q == S_IDLE || kbd_fall) begin
            timeout_d = '0;
        end else if (timeout_q == TO_LAST) begin
            state_d     = S_IDLE;
            timeout_d   = '0;
            frame_err_d = 1'b1;
        end else begin
            timeout_d = timeout_q + 16'd1;
        end

        if (kbd_fall) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!kbd_data) begin
                        state_d  = S_DATA;
                        bitcnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                S_DATA: begin
                    shift_d[bitcnt_q] = kbd_data;
                    if (bitcnt_q == 3'd7) state_d = S_PARITY;
                    else                  bitcnt_d = bitcnt_q + 3'd1;
                end
                S_PARITY: begin
                    parity_ok_d = ^shift_q ^ kbd_data;
                    state_d     = S_STOP;
                end
                S_STOP: begin
                    if (kbd_data && parity_ok_q) good_frame  = 1'b1;
                    else                         frame_err_d = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // A read on the delivery edge frees the slot, so the new byte lands
        // without flagging an overrun.
        if (rd_hit) begin
            data_ready_d = 1'b0;
            overrun_d    = 1'b0;
        end
        if (good_frame) begin
            if (!data_ready_q || rd_hit) begin
                scan_code_d  = shift_q;
                data_ready_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign ps2o_data_ready = data_ready_q;
    assign ps2o_scan_code  = scan_code_q;
    assign ps2o_frame_err  = frame_err_q;
    assign ps2o_overrun    = overrun_q;
    assign ps2o_busy       = (state_q != S_IDLE);

endmodule
